// File: rtl/bcd_pkg.sv
// Shared constants for the serial BCD subtractor: FSM encodings and BCD digit limits.
package bcd_pkg;

    localparam int DW = 4;
    localparam logic [DW-1:0] BCD_MAX   = 4'd9;
    localparam logic [DW:0]   BCD_RADIX = 5'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_bcd_digit(input logic [DW-1:0] dig);
        return dig <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow: d = x - y - bin, folded back into 0..9.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic          bin,
    output logic [DW-1:0] d,
    output logic          bout
);

    logic signed [DW:0] raw;
    logic        [DW:0] wrapped;

    // 5-bit signed range covers 0 - 9 - 1 = -10 without overflow
    assign raw     = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({{DW{1'b0}}, bin});
    assign wrapped = raw + BCD_RADIX;
    assign bout    = raw[DW];
    assign d       = bout ? wrapped[DW-1:0] : raw[DW-1:0];

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Serial multi-digit BCD subtractor, LSD first, sign-magnitude result.
// A negative raw result is converted from ten's complement by a second pass (FIX).
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4*NDIG-1:0]  a,
    input  logic [4*NDIG-1:0]  b,
    output logic               busy,
    output logic               done,
    output logic [4*NDIG-1:0]  diff,
    output logic               neg,
    output logic               err
);

    localparam int W  = DW * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [1:0]    state_reg;
    logic [W-1:0]  a_sh_reg;
    logic [W-1:0]  b_sh_reg;
    logic [W-1:0]  diff_reg;
    logic [IW-1:0] idx_reg;
    logic          brw_reg;
    logic          neg_reg;
    logic          err_reg;

    logic [DW-1:0]  diff_dig [NDIG];
    logic [2*NDIG-1:0] dig_ok;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
            assign diff_dig[gi]     = diff_reg[gi*DW +: DW];
            assign dig_ok[gi]       = is_bcd_digit(a[gi*DW +: DW]);
            assign dig_ok[NDIG+gi]  = is_bcd_digit(b[gi*DW +: DW]);
        end
    endgenerate

    logic          in_fix;
    logic          last_dig;
    logic [DW-1:0] unit_x;
    logic [DW-1:0] unit_y;
    logic [DW-1:0] unit_d;
    logic          unit_bout;

    assign in_fix   = (state_reg == ST_FIX);
    assign last_dig = (idx_reg == IW'(NDIG - 1));
    // FIX negates the stored ten's complement in place: 0 - diff_i - brw
    assign unit_x   = in_fix ? '0 : a_sh_reg[DW-1:0];
    assign unit_y   = in_fix ? diff_dig[idx_reg] : b_sh_reg[DW-1:0];

    bcd_digit_sub u_digit (
        .x    (unit_x),
        .y    (unit_y),
        .bin  (brw_reg),
        .d    (unit_d),
        .bout (unit_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            diff_reg  <= '0;
            idx_reg   <= '0;
            brw_reg   <= 1'b0;
            neg_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_reg <= a;
                        b_sh_reg <= b;
                        idx_reg  <= '0;
                        brw_reg  <= 1'b0;
                        neg_reg  <= 1'b0;
                        diff_reg <= '0;
                        if (&dig_ok) begin
                            err_reg   <= 1'b0;
                            state_reg <= ST_SUB;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_SUB: begin
                    a_sh_reg <= a_sh_reg >> DW;
                    b_sh_reg <= b_sh_reg >> DW;
                    for (int i = 0; i < NDIG; i++) begin
                        if (idx_reg == IW'(i)) diff_reg[i*DW +: DW] <= unit_d;
                    end
                    brw_reg <= unit_bout;
                    idx_reg <= idx_reg + 1'b1;
                    if (last_dig) begin
                        idx_reg <= '0;
                        if (unit_bout) begin
                            brw_reg   <= 1'b0;
                            state_reg <= ST_FIX;
                        end else begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_FIX: begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (idx_reg == IW'(i)) diff_reg[i*DW +: DW] <= unit_d;
                    end
                    brw_reg <= unit_bout;
                    idx_reg <= idx_reg + 1'b1;
                    if (last_dig) begin
                        idx_reg   <= '0;
                        brw_reg   <= 1'b0;
                        neg_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_SUB) || (state_reg == ST_FIX);
    assign done = (state_reg == ST_DONE);
    assign diff = diff_reg;
    assign neg  = neg_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (NDIG=4) against an integer reference model.
module tb_bcd_serial_subtractor;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, neg, err;
    logic [W-1:0] diff;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_serial_subtractor #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit bcd_ok(input logic [W-1:0] v);
        for (int i = 0; i < NDIG; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] e_diff, output logic e_neg,
                         output logic e_err, output int e_lat);
        int d;
        if (!bcd_ok(ma) || !bcd_ok(mb)) begin
            e_diff = '0; e_neg = 1'b0; e_err = 1'b1; e_lat = 1;
        end else begin
            d = bcd2int(ma) - bcd2int(mb);
            e_err  = 1'b0;
            e_neg  = (d < 0);
            e_diff = int2bcd(d < 0 ? -d : d);
            e_lat  = (d < 0) ? 2 * NDIG + 1 : NDIG + 1;
        end
    endtask

    // Drives one operation, scrambles operands after acceptance, waits (bounded) for done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          output logic [W-1:0] r_diff, output logic r_neg,
                          output logic r_err, output int lat);
        @(negedge clk);
        a = ta; b = tbv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        r_diff = diff; r_neg = neg; r_err = err;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                            input bit check_lat);
        logic [W-1:0] r_diff, e_diff;
        logic r_neg, r_err, e_neg, e_err;
        int lat, e_lat;
        model(ta, tbv, e_diff, e_neg, e_err, e_lat);
        run_op(ta, tbv, r_diff, r_neg, r_err, lat);
        n_cmp++;
        if (r_diff !== e_diff || r_neg !== e_neg || r_err !== e_err || (check_lat && lat != e_lat)) begin
            n_bad++;
            $display("FAIL %s a=%h b=%h: got diff=%h neg=%0d err=%0d lat=%0d, want diff=%h neg=%0d err=%0d lat=%0d",
                     name, ta, tbv, r_diff, r_neg, r_err, lat, e_diff, e_neg, e_err, e_lat);
        end else begin
            $display("ok   %s a=%h b=%h diff=%h neg=%0d err=%0d lat=%0d", name, ta, tbv, r_diff, r_neg, r_err, lat);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, neg, err, diff} !== '0) begin
            n_bad++;
            $display("FAIL reset: got busy=%0d done=%0d neg=%0d err=%0d diff=%h, want all 0",
                     busy, done, neg, err, diff);
        end else $display("ok   reset outputs zero");
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        check_op("case1",  16'h1234, 16'h0567, 1'b1);
        check_op("case2",  16'h0567, 16'h1234, 1'b1);
        check_op("0-1",    16'h0000, 16'h0001, 1'b1);
        check_op("eq9999", 16'h9999, 16'h9999, 1'b1);
        check_op("9999-0", 16'h9999, 16'h0000, 1'b1);
        check_op("0-9999", 16'h0000, 16'h9999, 1'b1);
    endtask

    task automatic test_err();
        check_op("err_a", 16'h12A4, 16'h0000, 1'b1);
        check_op("err_b", 16'h0000, 16'hF000, 1'b1);
        check_op("err_clear", 16'h0042, 16'h0017, 1'b1);
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int lat = -1;
        @(negedge clk);
        a = 16'h1234; b = 16'h0567; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 2) begin a = 16'h0001; b = 16'h0999; start = 1'b1; end
            if (c == 3) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    n_cmp++;
                    if (diff !== 16'h0667 || neg !== 1'b0) begin
                        n_bad++;
                        $display("FAIL ignore_result: got diff=%h neg=%0d, want 0667 neg=0", diff, neg);
                    end
                    start = 1'b1;  // start during the DONE cycle must be ignored
                end
            end
            @(negedge clk);
            if (lat > 0 && c == lat) start = 1'b0;
        end
        n_cmp++;
        if (ndone != 1 || lat != NDIG + 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_start: got dones=%0d lat=%0d busy=%0d, want dones=1 lat=%0d busy=0",
                     ndone, lat, busy, NDIG + 1);
        end else $display("ok   ignore_start dones=%0d lat=%0d", ndone, lat);
    endtask

    task automatic test_reset_midop();
        int ndone = 0;
        @(negedge clk);
        a = 16'h0567; b = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({busy, done, neg, err, diff} !== '0) begin
            n_bad++;
            $display("FAIL midop_reset: got busy=%0d done=%0d neg=%0d err=%0d diff=%h, want all 0",
                     busy, done, neg, err, diff);
        end else $display("ok   midop_reset outputs zero");
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL midop_no_done: got %0d done pulses, want 0", ndone);
        end else $display("ok   midop_no_done");
        check_op("after_reset", 16'h0567, 16'h1234, 1'b1);
    endtask

    task automatic test_exhaustive_digit();
        logic [W-1:0] r_diff, e_diff;
        logic r_neg, r_err, e_neg, e_err;
        int lat, e_lat;
        for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
                int dd = x - y;
                e_diff = int2bcd(dd < 0 ? -dd : dd);
                e_neg  = (dd < 0);
                e_err  = 1'b0;
                e_lat  = (dd < 0) ? 2 * NDIG + 1 : NDIG + 1;
                run_op(W'(x), W'(y), r_diff, r_neg, r_err, lat);
                n_cmp++;
                if (r_diff !== e_diff || r_neg !== e_neg || r_err !== e_err || lat != e_lat) begin
                    n_bad++;
                    $display("FAIL digit %0d-%0d: got diff=%h neg=%0d err=%0d lat=%0d, want diff=%h neg=%0d lat=%0d",
                             x, y, r_diff, r_neg, r_err, lat, e_diff, e_neg, e_lat);
                end
            end
        end
        $display("ok   exhaustive digit loop finished");
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        for (int n = 0; n < 60; n++) begin
            ra = int2bcd($urandom_range(0, 9999));
            rb = int2bcd($urandom_range(0, 9999));
            if ($urandom_range(0, 9) == 0) ra[$urandom_range(0, NDIG - 1) * 4 +: 4] = 4'($urandom_range(10, 15));
            check_op("random", ra, rb, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_err();
        test_ignore_start();
        test_reset_midop();
        test_exhaustive_digit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
